friscv_axi4_rd_responder: RTL and testbench

AXI4 read-channel responder (slave) fronting a single-port synchronous RAM/ROM with 1-cycle read latency. Accepts one read burst at a time on AR, streams the beats back on R with correct RID/RLAST, and tolerates arbitrary RREADY backpressure through a 2-entry output buffer. It is the memory-side counterpart of the instruction/data cache memory controllers and serves as the central instruction memory in the platform.

---
 rtl/friscv_axi4_rd_responder_pkg.sv | 15 +
 rtl/friscv_axi4_rd_responder_scfifo.sv | 59 +++++
 rtl/friscv_axi4_rd_responder.sv | 139 +++++++++++++
 tb/tb_friscv_axi4_rd_responder.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/friscv_axi4_rd_responder_pkg.sv
// Shared AXI encodings and responder state type.
package friscv_h;

  localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } rd_state_t;

endpackage

// File: rtl/friscv_axi4_rd_responder_scfifo.sv
// Single-clock FIFO; head entry is presented combinationally on data_out.
module friscv_scfifo #(
  parameter  int DEPTH = 2,
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             srst,
  input  logic             push,
  input  logic [WIDTH-1:0] data_in,
  input  logic             pop,
  output logic [WIDTH-1:0] data_out,
  output logic             empty,
  output logic             full,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (srst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= data_in;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (do_pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  assign data_out = mem_q[rd_ptr_q];
  assign empty    = (count_q == '0);
  assign full     = (count_q == CNT_W'(DEPTH));
  assign count    = count_q;

endmodule

// File: rtl/friscv_axi4_rd_responder.sv
// AXI4 read responder in front of a 1-cycle-latency RAM, one burst at a time.
//   state | meaning
//   IDLE  | arready high, waiting for an AR handshake
//   BURST | issuing RAM reads by credit, streaming beats until rlast handshake
module friscv_axi4_rd_responder
  import friscv_h::*;
#(
  parameter int XLEN       = 32,
  parameter int ADDR_W     = 16,
  parameter int AXI_ID_W   = 8,
  parameter int AXI_DATA_W = 128,
  parameter int RAM_ADDR_W = ADDR_W - $clog2(AXI_DATA_W / 8)
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  srst,
  input  logic                  mem_arvalid,
  output logic                  mem_arready,
  input  logic [ADDR_W-1:0]     mem_araddr,
  input  logic [7:0]            mem_arlen,
  input  logic [2:0]            mem_arsize,
  input  logic [1:0]            mem_arburst,
  input  logic [AXI_ID_W-1:0]   mem_arid,
  input  logic [1:0]            mem_arlock,
  input  logic [3:0]            mem_arcache,
  input  logic [2:0]            mem_arprot,
  input  logic [3:0]            mem_arqos,
  input  logic [3:0]            mem_arregion,
  output logic                  mem_rvalid,
  input  logic                  mem_rready,
  output logic [AXI_ID_W-1:0]   mem_rid,
  output logic [1:0]            mem_rresp,
  output logic [AXI_DATA_W-1:0] mem_rdata,
  output logic                  mem_rlast,
  output logic                  ram_en,
  output logic [RAM_ADDR_W-1:0] ram_addr,
  input  logic [AXI_DATA_W-1:0] ram_rdata
);

  localparam int OFFSET_W = $clog2(AXI_DATA_W / 8);

  rd_state_t             state_q, state_d;
  logic                  arready_q;
  logic [AXI_ID_W-1:0]   id_q;
  logic [RAM_ADDR_W-1:0] addr_q;
  logic                  fixed_q;
  logic [8:0]            remaining_q;
  logic                  inflight_q;
  logic                  inflight_last_q;

  logic                  ar_hs;
  logic                  pop;
  logic                  fifo_empty;
  logic                  fifo_full;
  logic [1:0]            fifo_count;
  logic [AXI_DATA_W-1:0] head_data;
  logic                  head_last;
  logic [2:0]            credit_used;
  logic                  unused_sig;

  assign ar_hs = mem_arvalid & arready_q;
  assign pop   = mem_rvalid & mem_rready;

  // A read may issue only if the FIFO can still hold it once everything in flight lands.
  assign credit_used = 3'(fifo_count) + 3'(inflight_q);
  assign ram_en      = (state_q == BURST) && (remaining_q != '0) &&
                       (credit_used < (3'd2 + 3'(pop)));
  assign ram_addr    = addr_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (ar_hs) state_d = BURST;
      BURST:   if (pop && head_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q         <= IDLE;
      arready_q       <= 1'b0;
      id_q            <= '0;
      addr_q          <= '0;
      fixed_q         <= 1'b0;
      remaining_q     <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else if (srst) begin
      state_q         <= IDLE;
      arready_q       <= 1'b0;
      remaining_q     <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      arready_q       <= (state_d == IDLE);
      inflight_q      <= ram_en;
      inflight_last_q <= ram_en && (remaining_q == 9'd1);
      if (ar_hs) begin
        id_q        <= mem_arid;
        addr_q      <= mem_araddr[ADDR_W-1:OFFSET_W];
        fixed_q     <= (mem_arburst == AXI_BURST_FIXED);
        remaining_q <= {1'b0, mem_arlen} + 9'd1;
      end else if (ram_en) begin
        remaining_q <= remaining_q - 9'd1;
        // Word address wraps naturally at the top of the byte space.
        if (!fixed_q) addr_q <= addr_q + 1'b1;
      end
    end
  end

  friscv_scfifo #(
    .DEPTH (2),
    .WIDTH (AXI_DATA_W + 1)
  ) u_rfifo (
    .aclk     (aclk),
    .aresetn  (aresetn),
    .srst     (srst),
    .push     (inflight_q),
    .data_in  ({ram_rdata, inflight_last_q}),
    .pop      (pop),
    .data_out ({head_data, head_last}),
    .empty    (fifo_empty),
    .full     (fifo_full),
    .count    (fifo_count)
  );

  assign mem_arready = arready_q;
  assign mem_rvalid  = ~fifo_empty;
  assign mem_rdata   = head_data;
  assign mem_rlast   = ~fifo_empty & head_last;
  assign mem_rid     = id_q;
  assign mem_rresp   = RESP_OKAY;

  assign unused_sig = ^{32'(XLEN), mem_arsize, mem_arlock, mem_arcache, mem_arprot,
                        mem_arqos, mem_arregion, mem_araddr[OFFSET_W-1:0], fifo_full};

endmodule

// File: tb/tb_friscv_axi4_rd_responder.sv
// Randomized bench for friscv_axi4_rd_responder with a burst-level reference model.
module tb_friscv_axi4_rd_responder;

  logic         aclk = 1'b0;
  logic         aresetn = 1'b0;
  logic         srst = 1'b0;
  logic         mem_arvalid = 1'b0;
  logic         mem_arready;
  logic [15:0]  mem_araddr = '0;
  logic [7:0]   mem_arlen = '0;
  logic [2:0]   mem_arsize = 3'd4;
  logic [1:0]   mem_arburst = 2'b01;
  logic [7:0]   mem_arid = '0;
  logic [1:0]   mem_arlock = '0;
  logic [3:0]   mem_arcache = '0;
  logic [2:0]   mem_arprot = '0;
  logic [3:0]   mem_arqos = '0;
  logic [3:0]   mem_arregion = '0;
  logic         mem_rvalid;
  logic         mem_rready = 1'b0;
  logic [7:0]   mem_rid;
  logic [1:0]   mem_rresp;
  logic [127:0] mem_rdata;
  logic         mem_rlast;
  logic         ram_en;
  logic [11:0]  ram_addr;
  logic [127:0] ram_rdata = '0;

  friscv_axi4_rd_responder dut (
    .aclk(aclk), .aresetn(aresetn), .srst(srst),
    .mem_arvalid(mem_arvalid), .mem_arready(mem_arready), .mem_araddr(mem_araddr),
    .mem_arlen(mem_arlen), .mem_arsize(mem_arsize), .mem_arburst(mem_arburst),
    .mem_arid(mem_arid), .mem_arlock(mem_arlock), .mem_arcache(mem_arcache),
    .mem_arprot(mem_arprot), .mem_arqos(mem_arqos), .mem_arregion(mem_arregion),
    .mem_rvalid(mem_rvalid), .mem_rready(mem_rready), .mem_rid(mem_rid),
    .mem_rresp(mem_rresp), .mem_rdata(mem_rdata), .mem_rlast(mem_rlast),
    .ram_en(ram_en), .ram_addr(ram_addr), .ram_rdata(ram_rdata)
  );

  always #5 aclk = ~aclk;

  logic [127:0] mem [0:4095];
  always @(posedge aclk) if (ram_en) ram_rdata <= mem[ram_addr];

  int errors = 0;
  int checks = 0;
  int pct = 100;

  // Reference model state.
  logic [11:0]  exp_addr_q [$];
  logic [128:0] exp_beats [$];
  logic [7:0]   exp_id;
  logic [127:0] got_q [$];
  logic         got_last_q [$];
  logic [7:0]   got_id;
  logic [11:0]  first_addr;
  int cyc = 0;
  int hs_cyc = 0;
  int expect_ar_cyc = -1;
  int outstanding = 0;
  int pop_cnt = 0;
  bit seen_en = 1'b1;
  bit seen_rv = 1'b1;
  bit prev_stall = 1'b0;
  logic [127:0] prev_data;
  logic prev_last;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic flag(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    errors++;
    $display("FAIL %s actual=%0h required=%0h", name, act, exp);
  endtask

  task automatic flush_model();
    exp_addr_q.delete();
    exp_beats.delete();
    outstanding   = 0;
    prev_stall    = 1'b0;
    expect_ar_cyc = -1;
    seen_en       = 1'b1;
    seen_rv       = 1'b1;
  endtask

  always @(negedge aclk) begin
    logic         pop;
    logic [128:0] eb;
    logic [11:0]  base;
    logic [11:0]  w;
    if (!aresetn) begin
      flush_model();
    end else begin
      pop = mem_rvalid & mem_rready;
      if (cyc == expect_ar_cyc) check("arready_after_last", mem_arready, 1);
      if (exp_beats.size() != 0) check("arready_low_in_burst", mem_arready, 0);
      if (ram_en) begin
        if (!seen_en) begin
          check("ram_en_latency", cyc - hs_cyc, 1);
          seen_en = 1'b1;
          first_addr = ram_addr;
        end
        if (exp_addr_q.size() == 0) flag("ram_en_spurious", ram_en, 0);
        else check("ram_addr", ram_addr, exp_addr_q.pop_front());
      end
      if (prev_stall) begin
        check("stall_rvalid", mem_rvalid, 1);
        check("stall_rdata", mem_rdata, prev_data);
        check("stall_rlast", mem_rlast, prev_last);
      end
      if (mem_rvalid) begin
        if (!seen_rv) begin
          check("first_beat_latency", cyc - hs_cyc, 3);
          seen_rv = 1'b1;
        end
        if (exp_beats.size() == 0) begin
          flag("rvalid_spurious", mem_rvalid, 0);
        end else begin
          eb = exp_beats[0];
          check("rdata", mem_rdata, eb[128:1]);
          check("rlast", mem_rlast, eb[0]);
          check("rid", mem_rid, exp_id);
          check("rresp", mem_rresp, 0);
          if (pop) begin
            void'(exp_beats.pop_front());
            got_q.push_back(mem_rdata);
            got_last_q.push_back(mem_rlast);
            got_id = mem_rid;
            pop_cnt++;
            if (eb[0]) expect_ar_cyc = cyc + 1;
          end
        end
      end
      outstanding = outstanding + int'(ram_en) - int'(pop);
      if (ram_en) check("outstanding_le_2", outstanding <= 2, 1);
      prev_stall = mem_rvalid & ~mem_rready;
      prev_data  = mem_rdata;
      prev_last  = mem_rlast;
      if (mem_arvalid && mem_arready) begin
        base = mem_araddr[15:4];
        for (int i = 0; i <= int'(mem_arlen); i++) begin
          w = (mem_arburst == 2'b00) ? base : 12'(int'(base) + i);
          exp_addr_q.push_back(w);
          exp_beats.push_back({mem[w], i == int'(mem_arlen)});
        end
        exp_id  = mem_arid;
        hs_cyc  = cyc;
        seen_en = 1'b0;
        seen_rv = 1'b0;
      end
      if (srst) flush_model();
      cyc++;
    end
  end

  initial forever begin
    @(posedge aclk);
    #1 mem_rready = ($urandom_range(99) < pct);
  end

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic do_ar(input logic [15:0] a, input logic [7:0] l, input logic [1:0] b,
                       input logic [7:0] id);
    int n = 0;
    mem_arvalid  = 1'b1;
    mem_araddr   = a;
    mem_arlen    = l;
    mem_arburst  = b;
    mem_arid     = id;
    mem_arsize   = 3'($urandom_range(7));
    mem_arcache  = 4'($urandom_range(15));
    mem_arprot   = 3'($urandom_range(7));
    mem_arqos    = 4'($urandom_range(15));
    mem_arregion = 4'($urandom_range(15));
    mem_arlock   = 2'($urandom_range(3));
    do begin
      @(negedge aclk);
      n++;
    end while (!mem_arready && n < 300);
    if (!mem_arready) flag("ar_timeout", mem_arready, 1);
    step();
    mem_arvalid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((exp_beats.size() != 0 || !mem_arready) && n < budget) begin
      @(negedge aclk);
      n++;
    end
    check("idle_reached", (exp_beats.size() == 0) && mem_arready, 1);
  endtask

  task automatic wait_pops(input int k);
    int n = 0;
    while (pop_cnt < k && n < 100) begin
      @(negedge aclk);
      n++;
    end
    check("pops_reached", pop_cnt >= k, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_arready"}, mem_arready, 0);
    check({tag, "_rvalid"}, mem_rvalid, 0);
    check({tag, "_rlast"}, mem_rlast, 0);
    check({tag, "_rid"}, mem_rid, 0);
    check({tag, "_rdata"}, mem_rdata, 0);
    check({tag, "_rresp"}, mem_rresp, 0);
    check({tag, "_ram_en"}, ram_en, 0);
    check({tag, "_ram_addr"}, ram_addr, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = {$urandom, $urandom, $urandom, $urandom};
    repeat (3) @(posedge aclk);
    #1;
    check_reset_outputs("reset");
    aresetn = 1'b1;
    @(negedge aclk);
    check("arready_held_after_release", mem_arready, 0);
    step();
    check("arready_first_edge", mem_arready, 1);

    // single beat
    pct = 100;
    got_q.delete(); got_last_q.delete();
    do_ar(16'h0010, 8'd0, 2'b01, 8'h5A);
    wait_idle(50);
    check("single_count", got_q.size(), 1);
    check("single_data", got_q[0], mem[1]);
    check("single_last", got_last_q[0], 1);
    check("single_id", got_id, 8'h5A);
    check("single_ram_addr", first_addr, 12'h001);

    // INCR burst of 8
    step();
    got_q.delete(); got_last_q.delete();
    do_ar(16'h0000, 8'd7, 2'b01, 8'h01);
    wait_idle(60);
    check("incr_count", got_q.size(), 8);
    check("incr_data0", got_q[0], mem[0]);
    check("incr_data7", got_q[7], mem[7]);
    check("incr_last6", got_last_q[6], 0);
    check("incr_last7", got_last_q[7], 1);

    // backpressure
    step();
    pct = 30;
    got_q.delete(); got_last_q.delete();
    do_ar(16'h0200, 8'd15, 2'b01, 8'h33);
    wait_idle(400);
    check("bp_count", got_q.size(), 16);
    check("bp_data15", got_q[15], mem[12'h02F]);

    // FIXED, unaligned
    step();
    pct = 60;
    got_q.delete(); got_last_q.delete();
    do_ar(16'h0013, 8'd3, 2'b00, 8'h44);
    wait_idle(200);
    check("fixed_count", got_q.size(), 4);
    for (int i = 0; i < 4; i++) check("fixed_data", got_q[i], mem[1]);

    // address wrap
    step();
    pct = 100;
    got_q.delete(); got_last_q.delete();
    do_ar(16'hFFF0, 8'd1, 2'b01, 8'h55);
    wait_idle(50);
    check("wrap_count", got_q.size(), 2);
    check("wrap_data0", got_q[0], mem[12'hFFF]);
    check("wrap_data1", got_q[1], mem[12'h000]);

    // soft reset mid-burst
    step();
    pop_cnt = 0;
    do_ar(16'h0100, 8'd7, 2'b01, 8'h11);
    wait_pops(3);
    step();
    srst = 1'b1;
    step();
    srst = 1'b0;
    check("srst_rvalid", mem_rvalid, 0);
    check("srst_arready_low", mem_arready, 0);
    step();
    check("srst_arready_high", mem_arready, 1);
    got_q.delete(); got_last_q.delete();
    do_ar(16'h0040, 8'd3, 2'b10, 8'h22);
    wait_idle(50);
    check("post_srst_count", got_q.size(), 4);
    check("post_srst_data0", got_q[0], mem[4]);
    check("post_srst_id", got_id, 8'h22);

    // async reset mid-burst
    step();
    pop_cnt = 0;
    do_ar(16'h0300, 8'd7, 2'b01, 8'h77);
    wait_pops(2);
    step();
    #2 aresetn = 1'b0;
    #1 check_reset_outputs("areset");
    step();
    step();
    aresetn = 1'b1;
    @(negedge aclk);
    check("areset_arready_held", mem_arready, 0);
    step();
    check("areset_arready_rise", mem_arready, 1);

    // random back-to-back bursts
    for (int k = 0; k < 30; k++) begin
      pct = $urandom_range(20, 100);
      do_ar(16'($urandom), 8'($urandom_range(15)), 2'($urandom_range(2)), 8'($urandom));
    end
    wait_idle(600);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
